// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
//   Shared definitions for the LIFO command path.
//   - opcode_e : command opcodes carried in the upper field of the LIFO
//                command vector.
//   - state_e  : state encoding of the lifo_cmd_gen request FSM.
//   - log2     : ceiling log2, used to size occupancy counters.
// -----------------------------------------------------------------------------
package lifo_pkg;

    // Opcode field of the {opcode, data} command vector.
    typedef enum logic [1:0] {
        DO_NOTHING = 2'b00,
        POP        = 2'b01,
        PUSH       = 2'b10,
        INVALID    = 2'b11   // reserved, never emitted
    } opcode_e;

    // Request FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,    // ready for a host request
        ST_ISSUE = 2'b01,    // command is on vector_out this cycle
        ST_WAIT  = 2'b10     // pop only: waiting for LIFO data_out to settle
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int log2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage : lifo_pkg

// File: rtl/lifo_occ_counter.sv
// -----------------------------------------------------------------------------
// lifo_occ_counter
//   Up/down occupancy counter that mirrors the fill level of the attached LIFO.
//   The count is held at its bounds: an inc at full or a dec at empty is
//   ignored, and simultaneous inc/dec cancel out.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears the count
//   inc    in   one entry was pushed
//   dec    in   one entry was popped
//   count  out  current occupancy, 0..NUM_ENTRIES
//   full   out  count == NUM_ENTRIES
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module lifo_occ_counter
    import lifo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_WIDTH   = log2(NUM_ENTRIES) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(NUM_ENTRIES);

    assign full  = (count == MAX_COUNT);
    assign empty = (count == '0);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every always_ff reads the pre-edge value of every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule : lifo_occ_counter

// File: rtl/lifo_cmd_gen.sv
// -----------------------------------------------------------------------------
// lifo_cmd_gen
//   Command-side driver for a LIFO. Accepts push/pop requests from a host over
//   a valid/ready handshake, encodes them as one-cycle {opcode, data} commands
//   for the LIFO's vector_in port, and returns a one-cycle response carrying
//   the popped value. Over- and under-flow are caught against a local
//   occupancy count before any command is issued.
//
//   Optional feature macro: LIFO_CMD_GEN_ERR_EN
//     defined   : an illegal request (push at full, pop at empty) produces a
//                 response with rsp_err=1 on the following cycle.
//     undefined : illegal requests are consumed silently, rsp_err is tied 0.
//   The command stream and count are the same in both builds.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   req_valid     in   host request present
//   req_op        in   0 = push, 1 = pop
//   req_data      in   push payload (ignored for pop)
//   req_ready     out  request can be accepted (IDLE only, registered)
//   vector_out    out  {opcode, data} command to LIFO vector_in
//   lifo_data_in  in   LIFO data_out
//   rsp_valid     out  one-cycle response pulse
//   rsp_data      out  popped value, 0 for push or error
//   rsp_err       out  request was rejected
//   count         out  current occupancy, 0..NUM_ENTRIES
// -----------------------------------------------------------------------------
module lifo_cmd_gen
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_ENTRIES  = 4,
    parameter int OPCODE_WIDTH = 2,
    parameter int CNT_WIDTH    = log2(NUM_ENTRIES) + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    input  logic                               req_op,
    input  logic [DATA_WIDTH-1:0]              req_data,
    output logic                               req_ready,
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out,
    input  logic [DATA_WIDTH-1:0]              lifo_data_in,
    output logic                               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_err,
    output logic [CNT_WIDTH-1:0]               count
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NONE = OPCODE_WIDTH'(DO_NOTHING);
    localparam logic [OPCODE_WIDTH-1:0] OP_POP  = OPCODE_WIDTH'(POP);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH = OPCODE_WIDTH'(PUSH);

`ifdef LIFO_CMD_GEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    state_e state;
    logic   pending_pop;   // operation of the command currently in flight
    logic   full;
    logic   empty;
    logic   accept;
    logic   legal;
    logic   do_push;
    logic   do_pop;

    // ------------------------------------------------------------------
    // Request decode. req_ready is only ever high in IDLE, so an accept
    // always belongs to the IDLE state.
    // ------------------------------------------------------------------
    assign accept  = req_valid && req_ready;
    assign legal   = req_op ? !empty : !full;
    assign do_push = accept && legal && !req_op;
    assign do_pop  = accept && legal &&  req_op;

    // The counter moves on the accept edge, so count already reflects the
    // command while it is on vector_out.
    lifo_occ_counter #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_occ_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (do_push),
        .dec   (do_pop),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // ------------------------------------------------------------------
    // Request FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending_pop <= 1'b0;
            req_ready   <= 1'b0;
            vector_out  <= {OP_NONE, {DATA_WIDTH{1'b0}}};
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            // Command and response are single-cycle pulses; each state below
            // only overrides these defaults on the cycle it raises one.
            vector_out <= {OP_NONE, {DATA_WIDTH{1'b0}}};
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;

            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        if (legal) begin
                            pending_pop <= req_op;
                            req_ready   <= 1'b0;
                            state       <= ST_ISSUE;
                            vector_out  <= req_op ? {OP_POP, {DATA_WIDTH{1'b0}}}
                                                  : {OP_PUSH, req_data};
                        end else begin
                            // Rejected: nothing issued, stay ready for a
                            // back-to-back request.
                            rsp_valid <= ERR_EN;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (pending_pop) begin
                        // The LIFO registers data_out on this edge; sample it
                        // one cycle later from WAIT.
                        state <= ST_WAIT;
                    end else begin
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= lifo_data_in;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    req_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error flag: registered alongside rsp_valid when enabled, constant 0
    // otherwise.
    // ------------------------------------------------------------------
`ifdef LIFO_CMD_GEN_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= accept && !legal;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule : lifo_cmd_gen

// File: tb/tb_lifo_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_lifo_cmd_gen
//   Directed self-checking bench for lifo_cmd_gen with a behavioural LIFO
//   attached to vector_out / lifo_data_in. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_lifo_cmd_gen;

    localparam int DW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_op;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic [5:0]    vector_out;
    logic [DW-1:0] lifo_data_in;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lifo_cmd_gen #(
        .DATA_WIDTH   (4),
        .NUM_ENTRIES  (4),
        .OPCODE_WIDTH (2),
        .CNT_WIDTH    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .vector_out   (vector_out),
        .lifo_data_in (lifo_data_in),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .count        (count)
    );

    // Behavioural 4-deep LIFO: acts on the command present at each edge and
    // registers data_out on a pop.
    logic [DW-1:0] lifo_mem [4];
    int            lifo_sp;

    always @(posedge clk) begin
        if (reset) begin
            lifo_sp      <= 0;
            lifo_data_in <= '0;
        end else begin
            case (vector_out[5:4])
                2'b10: if (lifo_sp < 4) begin
                    lifo_mem[lifo_sp] <= vector_out[3:0];
                    lifo_sp           <= lifo_sp + 1;
                end
                2'b01: if (lifo_sp > 0) begin
                    lifo_data_in <= lifo_mem[lifo_sp-1];
                    lifo_sp      <= lifo_sp - 1;
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Legal push; req_valid is held one extra edge while req_ready is low to
    // show that it is not consumed twice.
    task automatic do_push(input logic [DW-1:0] d, input int exp_cnt);
        check("push_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = d;
        tick();                                   // accept edge N
        check("push_vec",       32'(vector_out), 32'({2'b10, d}));
        check("push_cnt",       32'(count),      32'(exp_cnt));
        check("push_busy",      32'(req_ready),  32'd0);
        check("push_no_rsp",    32'(rsp_valid),  32'd0);
        tick();                                   // N+1
        req_valid = 1'b0;
        check("push_vec_idle",  32'(vector_out), 32'd0);
        check("push_rsp_valid", 32'(rsp_valid),  32'd1);
        check("push_rsp_err",   32'(rsp_err),    32'd0);
        check("push_rsp_data",  32'(rsp_data),   32'd0);
        check("push_ready_ret", 32'(req_ready),  32'd1);
        check("push_cnt_hold",  32'(count),      32'(exp_cnt));
        tick();                                   // N+2
        check("push_rsp_drop",  32'(rsp_valid),  32'd0);
        check("push_vec_quiet", 32'(vector_out), 32'd0);
    endtask

    // Legal pop; req_valid held until req_ready returns.
    task automatic do_pop(input logic [DW-1:0] exp_data, input int exp_cnt);
        check("pop_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_data  = 4'hF;
        tick();                                   // accept edge N
        check("pop_vec",        32'(vector_out), 32'h10);
        check("pop_cnt",        32'(count),      32'(exp_cnt));
        check("pop_busy",       32'(req_ready),  32'd0);
        check("pop_no_rsp",     32'(rsp_valid),  32'd0);
        tick();                                   // N+1
        check("pop_vec_idle",   32'(vector_out), 32'd0);
        check("pop_wait_rsp",   32'(rsp_valid),  32'd0);
        check("pop_wait_busy",  32'(req_ready),  32'd0);
        tick();                                   // N+2
        req_valid = 1'b0;
        check("pop_rsp_valid",  32'(rsp_valid),  32'd1);
        check("pop_rsp_data",   32'(rsp_data),   32'(exp_data));
        check("pop_rsp_err",    32'(rsp_err),    32'd0);
        check("pop_ready_ret",  32'(req_ready),  32'd1);
        check("pop_vec_quiet",  32'(vector_out), 32'd0);
        check("pop_cnt_hold",   32'(count),      32'(exp_cnt));
        tick();                                   // N+3
        check("pop_rsp_drop",   32'(rsp_valid),  32'd0);
    endtask

    // Illegal request: no command, count unchanged, error response only in
    // the error-enabled build, and the block stays ready.
    task automatic do_illegal(input logic op, input int exp_cnt);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = 4'h5;
        tick();                                   // accept edge N
        req_valid = 1'b0;
        check("ill_vec",   32'(vector_out), 32'd0);
        check("ill_cnt",   32'(count),      32'(exp_cnt));
        check("ill_ready", 32'(req_ready),  32'd1);
        check("ill_data",  32'(rsp_data),   32'd0);
`ifdef LIFO_CMD_GEN_ERR_EN
        check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ill_rsp_err",   32'(rsp_err),   32'd1);
`else
        check("ill_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ill_rsp_err",   32'(rsp_err),   32'd0);
`endif
        tick();
        check("ill_rsp_drop", 32'(rsp_valid),  32'd0);
        check("ill_err_drop", 32'(rsp_err),    32'd0);
        check("ill_vec_post", 32'(vector_out), 32'd0);
        check("ill_cnt_post", 32'(count),      32'(exp_cnt));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;

        // Reset state.
        tick();
        tick();
        check("rst_vec",   32'(vector_out), 32'd0);
        check("rst_ready", 32'(req_ready),  32'd0);
        check("rst_valid", 32'(rsp_valid),  32'd0);
        check("rst_err",   32'(rsp_err),    32'd0);
        check("rst_data",  32'(rsp_data),   32'd0);
        check("rst_cnt",   32'(count),      32'd0);

        // Idle for 5 cycles; ready from the first post-reset cycle.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_ready", 32'(req_ready),  32'd1);
            check("idle_vec",   32'(vector_out), 32'd0);
            check("idle_valid", 32'(rsp_valid),  32'd0);
            check("idle_cnt",   32'(count),      32'd0);
        end

        // Fill the LIFO.
        do_push(4'hA, 1);
        do_push(4'h3, 2);
        do_push(4'h7, 3);
        do_push(4'h1, 4);

        // Overflow attempt, then a back-to-back second attempt.
        do_illegal(1'b0, 4);
        do_illegal(1'b0, 4);

        // Drain: last in, first out.
        do_pop(4'h1, 3);
        do_pop(4'h7, 2);
        do_pop(4'h3, 1);
        do_pop(4'hA, 0);

        // Underflow attempt.
        do_illegal(1'b1, 0);

        // Reset while a pop is in WAIT.
        do_push(4'h6, 1);
        req_valid = 1'b1;
        req_op    = 1'b1;
        tick();                                   // pop accepted
        check("mid_pop_vec", 32'(vector_out), 32'h10);
        tick();                                   // now in WAIT
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        check("mid_rst_vec",   32'(vector_out), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid),  32'd0);
        check("mid_rst_cnt",   32'(count),      32'd0);
        check("mid_rst_ready", 32'(req_ready),  32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);

        // Normal operation resumes.
        do_push(4'h9, 1);
        do_pop(4'h9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lifo_cmd_gen
